// File: rtl/tour_pkg.sv
// Shared types and constants for the command scheduler: FSM state encoding,
// the response acknowledge byte and the command opcode nibbles.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_SNT,
      WAIT_RESP,
      DONE,
      ERR
   } sched_state_e;

   localparam int unsigned CMD_W = 16;

   // Response byte that acknowledges a command.
   localparam logic [7:0] RESP_ACK = 8'hA5;

   // Opcodes live in the top nibble of a command word.
   localparam logic [3:0] OP_CAL_GYRO  = 4'h2;
   localparam logic [3:0] OP_MOVE      = 4'h4;
   localparam logic [3:0] OP_MOVE_FAST = 4'h5;

   function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] c);
      return c[CMD_W-1 -: 4];
   endfunction

   // States in which a command is being worked on.
   function automatic logic is_busy_state(input sched_state_e s);
      return (s == LOAD) || (s == SEND) || (s == WAIT_SNT) || (s == WAIT_RESP);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH-entry circular buffer with full/empty status and a
// flush that empties the queue in one cycle. A push into a full queue is
// dropped unless a pop happens in the same cycle. Flush wins over push/pop.
module cmd_fifo
   import tour_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = CMD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/cmd_scheduler.sv
// Command scheduler: queues command words and drains them one by one to
// RemoteComm, waiting for cmd_snt and an acknowledge byte per command.
// Optional feature macro: CMD_RETRY_EN -- on the first response timeout of a
// command, re-send it once before declaring an error.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | waiting for start
//   LOAD      | pop queue head into the cmd register
//   SEND      | snd_cmd strobe high for this one cycle
//   WAIT_SNT  | waiting for RemoteComm to finish transmitting
//   WAIT_RESP | waiting for the response byte, timeout counter running
//   DONE      | sequence complete, every command acknowledged
//   ERR       | command nacked or timed out; err_cmd holds it
module cmd_scheduler
   import tour_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESP_TMO = 32'd40_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [15:0] push_cmd,
   input  logic        start,
   input  logic        abort,
   output logic        snd_cmd,
   output logic [15:0] cmd,
   input  logic        cmd_snt,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        full,
   output logic        empty,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [4:0]  n_done,
   output logic [15:0] err_cmd
);

   sched_state_e state_q, state_d;
   logic [15:0]  cmd_q, cmd_d;
   logic [15:0]  err_cmd_q, err_cmd_d;
   logic [4:0]   n_done_q, n_done_d;
   logic [31:0]  tmo_q, tmo_d;
   logic         snd_q, snd_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
`ifdef CMD_RETRY_EN
   logic         retry_q, retry_d;
`endif

   logic         fifo_pop;
   logic         fifo_flush;
   logic [15:0]  fifo_head;
   logic         tmo_hit;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (16)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_cmd),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .rdata (fifo_head),
      .full  (full),
      .empty (empty)
   );

   assign tmo_hit = (tmo_q == RESP_TMO - 32'd1);

   // The strobe is registered, but an abort in the same cycle suppresses it.
   assign snd_cmd = snd_q && !abort;
   assign cmd     = cmd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign n_done  = n_done_q;
   assign err_cmd = err_cmd_q;

   // Next-state and datapath decisions; abort overrides everything.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      err_cmd_d  = err_cmd_q;
      n_done_d   = n_done_q;
      tmo_d      = tmo_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
`ifdef CMD_RETRY_EN
      retry_d    = retry_q;
`endif
      if (abort) begin
         state_d    = IDLE;
         fifo_flush = 1'b1;
         tmo_d      = '0;
      end else begin
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  n_done_d = '0;
                  state_d  = empty ? DONE : LOAD;
               end
            end
            LOAD: begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               tmo_d    = '0;
`ifdef CMD_RETRY_EN
               retry_d  = 1'b0;
`endif
               state_d  = SEND;
            end
            SEND: begin
               state_d = WAIT_SNT;
            end
            WAIT_SNT: begin
               if (cmd_snt) begin
                  tmo_d   = '0;
                  state_d = WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (resp_rdy) begin
                  if (resp == RESP_ACK) begin
                     if (n_done_q != 5'd31) n_done_d = n_done_q + 5'd1;
`ifdef CMD_RETRY_EN
                     retry_d = 1'b0;
`endif
                     state_d = empty ? DONE : LOAD;
                  end else begin
                     err_cmd_d = cmd_q;
                     state_d   = ERR;
                  end
               end else if (tmo_hit) begin
`ifdef CMD_RETRY_EN
                  if (!retry_q) begin
                     retry_d = 1'b1;
                     tmo_d   = '0;
                     state_d = SEND;
                  end else begin
                     err_cmd_d = cmd_q;
                     state_d   = ERR;
                  end
`else
                  err_cmd_d = cmd_q;
                  state_d   = ERR;
`endif
               end else begin
                  tmo_d = tmo_q + 32'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      snd_d  = (state_d == SEND);
      busy_d = is_busy_state(state_d);
      done_d = (state_d == DONE);
      err_d  = (state_d == ERR);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= 16'h0000;
         err_cmd_q <= 16'h0000;
         n_done_q  <= '0;
         tmo_q     <= '0;
         snd_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef CMD_RETRY_EN
         retry_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         err_cmd_q <= err_cmd_d;
         n_done_q  <= n_done_d;
         tmo_q     <= tmo_d;
         snd_q     <= snd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef CMD_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: directed scenarios plus randomized
// sequences checked against a queue-based model of the command flow.
module tb_cmd_scheduler;

   localparam int          DEPTH = 8;
   localparam logic [31:0] TMO   = 32'd100;
   localparam logic [7:0]  ACK   = 8'hA5;

   logic        clk = 1'b0;
   logic        rst, push, start, abort, cmd_snt, resp_rdy;
   logic [15:0] push_cmd;
   logic [7:0]  resp;
   logic        snd_cmd, full, empty, busy, done, err;
   logic [15:0] cmd, err_cmd;
   logic [4:0]  n_done;

   int          vectors = 0;
   int          miscompares = 0;
   int          snd_cnt = 0;
   int          exp_ndone;
   logic [15:0] mq[$];

   cmd_scheduler #(.DEPTH(DEPTH), .RESP_TMO(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_cmd (push_cmd),
      .start    (start),
      .abort    (abort),
      .snd_cmd  (snd_cmd),
      .cmd      (cmd),
      .cmd_snt  (cmd_snt),
      .resp_rdy (resp_rdy),
      .resp     (resp),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .n_done   (n_done),
      .err_cmd  (err_cmd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (snd_cmd === 1'b1) snd_cnt++;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_snd"},    snd_cmd, 0);
      check({tag, "_cmd"},    cmd, 0);
      check({tag, "_busy"},   busy, 0);
      check({tag, "_done"},   done, 0);
      check({tag, "_err"},    err, 0);
      check({tag, "_ndone"},  n_done, 0);
      check({tag, "_errcmd"}, err_cmd, 0);
      check({tag, "_empty"},  empty, 1);
      check({tag, "_full"},   full, 0);
   endtask

   // Model: a push is kept only if the queue has room.
   task automatic push_word(input logic [15:0] w);
      push = 1'b1;
      push_cmd = w;
      tick();
      push = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(w);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_snd_check(input string tag, input logic [15:0] exp);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         if (snd_cmd === 1'b1) seen = 1'b1;
         else tick();
      end
      check({tag, "_snd_seen"}, seen, 1);
      if (seen) check({tag, "_snd_cmd"}, cmd, exp);
   endtask

   // Called while the DUT waits for cmd_snt.
   task automatic finish_cmd(input logic [7:0] r, input int dsnt, input int dresp);
      repeat (dsnt) tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      repeat (dresp) tick();
      resp = r;
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
   endtask

   task automatic serve(input string tag, input logic [15:0] exp, input logic [7:0] r,
                        input int dsnt, input int dresp);
      wait_snd_check(tag, exp);
      tick();
      check({tag, "_snd_width"}, snd_cmd, 0);
      check({tag, "_busy"}, busy, 1);
      finish_cmd(r, dsnt, dresp);
   endtask

   // Drain the model queue; each command gets an ack unless randomly nacked.
   task automatic drain(input string tag, input int nack_pct);
      logic [15:0] w;
      logic [7:0]  r;
      bit          failed = 1'b0;
      w = 16'h0;
      while (mq.size() > 0 && !failed) begin
         w = mq.pop_front();
         r = ACK;
         if (int'($urandom_range(99)) < nack_pct) begin
            do r = 8'($urandom); while (r == ACK);
         end
         serve(tag, w, r, int'($urandom_range(3)), int'($urandom_range(3)));
         if (r == ACK) begin
            if (exp_ndone < 31) exp_ndone++;
         end else begin
            failed = 1'b1;
         end
      end
      check({tag, "_ndone"}, n_done, exp_ndone);
      check({tag, "_done"},  done, !failed);
      check({tag, "_err"},   err, failed);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_empty"}, empty, (mq.size() == 0));
      if (failed) check({tag, "_errcmd"}, err_cmd, w);
   endtask

   task automatic run_seq(input string tag, input int nack_pct);
      exp_ndone = 0;
      pulse_start();
      drain(tag, nack_pct);
   endtask

   initial begin
      int          n0;
      int          cyc;
      int          total;
      logic [15:0] w;

      rst = 1'b1; push = 1'b0; push_cmd = '0; start = 1'b0; abort = 1'b0;
      cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
      tick();
      tick();
      rst = 1'b0;
      check_reset("reset");

      // Two acknowledged commands in order.
      push_word(16'h2000);
      push_word(16'h43F1);
      n0 = snd_cnt;
      run_seq("two_ack", 0);
      check("two_ack_pulses", snd_cnt - n0, 2);

      // Start with nothing queued goes straight to DONE.
      n0 = snd_cnt;
      run_seq("empty_start", 0);
      check("empty_start_pulses", snd_cnt - n0, 0);

      // Nacked command.
      push_word(16'h43F1);
      exp_ndone = 0;
      pulse_start();
      w = mq.pop_front();
      serve("nack", w, 8'h5A, 1, 2);
      check("nack_err", err, 1);
      check("nack_errcmd", err_cmd, 16'h43F1);
      check("nack_ndone", n_done, 0);
      check("nack_done", done, 0);

      // Stray response outside WAIT_RESP changes nothing.
      resp = ACK; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
      check("stray_resp_err", err, 1);
      check("stray_resp_ndone", n_done, 0);

      // Response timeout.
      push_word(16'h1234);
      pulse_start();
      w = mq.pop_front();
      wait_snd_check("tmo", w);
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      cyc = 0;
      while (err !== 1'b1 && snd_cmd !== 1'b1 && cyc < 300) begin tick(); cyc++; end
`ifdef CMD_RETRY_EN
      check("tmo_retry_cycles", cyc, 100);
      check("tmo_retry_snd", snd_cmd, 1);
      check("tmo_retry_cmd", cmd, 16'h1234);
      check("tmo_retry_noerr", err, 0);
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      cyc = 0;
      while (err !== 1'b1 && snd_cmd !== 1'b1 && cyc < 300) begin tick(); cyc++; end
`endif
      check("tmo_cycles", cyc, 100);
      check("tmo_err", err, 1);
      check("tmo_snd", snd_cmd, 0);
      check("tmo_errcmd", err_cmd, 16'h1234);
      check("tmo_busy", busy, 0);

      // Nine pushes into an eight-deep queue: the ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         push_word(16'(i * 16'h0111 + 16'h4000));
         if (i == 7) check("fill_full8", full, 1);
      end
      check("fill_full9", full, 1);
      n0 = snd_cnt;
      run_seq("fill_drain", 0);
      check("fill_drain_pulses", snd_cnt - n0, 8);

      // Push while full in the same cycle as the LOAD pop is accepted.
      for (int i = 0; i < DEPTH; i++) push_word(16'(16'h5000 + i));
      check("pp_full", full, 1);
      n0 = snd_cnt;
      exp_ndone = 0;
      pulse_start();
      w = mq.pop_front();
      push_word(16'h5ABC);
      check("pp_still_full", full, 1);
      serve("pp_first", w, ACK, 0, 0);
      exp_ndone = 1;
      drain("pp_drain", 0);
      check("pp_pulses", snd_cnt - n0, 9);

      // Saturation of n_done while pushing during the sequence.
      for (int i = 0; i < DEPTH; i++) push_word(16'($urandom));
      total = DEPTH;
      exp_ndone = 0;
      pulse_start();
      while (mq.size() > 0) begin
         w = mq.pop_front();
         wait_snd_check("sat", w);
         if (total < 34) begin
            push_word(16'($urandom));
            total++;
         end else begin
            tick();
         end
         finish_cmd(ACK, 0, 1);
         if (exp_ndone < 31) exp_ndone++;
      end
      check("sat_ndone", n_done, exp_ndone);
      check("sat_done", done, 1);

      // Abort in WAIT_RESP with three commands still queued.
      for (int i = 0; i < 4; i++) push_word(16'(16'h6000 + i));
      pulse_start();
      w = mq.pop_front();
      wait_snd_check("abort", w);
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      check("abort_pre_empty", empty, 0);
      n0 = snd_cnt;
      abort = 1'b1; tick(); abort = 1'b0;
      mq.delete();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      check("abort_empty", empty, 1);
      resp = ACK; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
      repeat (20) tick();
      check("abort_no_snd", snd_cnt - n0, 0);
      check("abort_busy_late", busy, 0);
      run_seq("after_abort", 0);
      check("after_abort_pulses", snd_cnt - n0, 0);

      // Reset while waiting for cmd_snt.
      push_word(16'h7001);
      push_word(16'h7002);
      pulse_start();
      w = mq.pop_front();
      wait_snd_check("rst_mid", w);
      tick();
      rst = 1'b1; cmd_snt = 1'b1; tick(); rst = 1'b0; cmd_snt = 1'b0;
      mq.delete();
      check_reset("rst_mid");
      n0 = snd_cnt;
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      resp = ACK; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
      repeat (10) tick();
      check("rst_mid_no_snd", snd_cnt - n0, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ndone", n_done, 0);

      // Randomized sequences; nacked leftovers carry into the next start.
      for (int it = 0; it < 8; it++) begin
         int n;
         n = int'($urandom_range(DEPTH, 1));
         for (int k = 0; k < n; k++) push_word(16'($urandom));
         run_seq("rand", 15);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
